// File: rtl/circle_sprite_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// circle_sprite_scheduler: shares one circle-bitmap ROM between sprite slots,
// fetching next-line rows during hblank and drawing a per-pixel hit. Rev 1.0
// ---------------------------------------------------------------------------
module circle_sprite_scheduler #(
  parameter int N_SLOTS = 9,
  parameter int SPR     = 64,
  parameter int CW      = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     line_start,
  input  logic [CW-1:0]            next_y,
  input  logic [CW-1:0]            x,
  input  logic                     slot_we,
  input  logic [3:0]               slot_idx,
  input  logic                     slot_en,
  input  logic [CW-1:0]            slot_x,
  input  logic [CW-1:0]            slot_y,
  output logic [$clog2(SPR)-1:0]   rom_addr,
  input  logic [SPR-1:0]           rom_data,
  output logic                     busy,
  output logic                     pix_on,
  output logic [3:0]               pix_slot
);

  localparam int AW = $clog2(SPR);
  localparam int SW = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, COMMIT = 2'd2} state_t;

  state_t          state, state_nx;
  logic [SW-1:0]   s;
  logic [CW-1:0]   ny;
  logic            last;
  logic [CW:0]     d;
  logic            hit;

  logic            cfg_en   [N_SLOTS];
  logic [CW-1:0]   cfg_x    [N_SLOTS];
  logic [CW-1:0]   cfg_y    [N_SLOTS];
  logic [SPR-1:0]  shad_row [N_SLOTS];
  logic            shad_val [N_SLOTS];
  logic [CW-1:0]   shad_x   [N_SLOTS];
  logic [SPR-1:0]  act_row  [N_SLOTS];
  logic            act_val  [N_SLOTS];
  logic [CW-1:0]   act_x    [N_SLOTS];

  logic            on_nx;
  logic [3:0]      slot_nx;
  logic [CW:0]     dx;

  assign busy = (state != IDLE);

  always_comb begin
    d        = {1'b0, ny} - {1'b0, cfg_y[s]};
    hit      = cfg_en[s] && !d[CW] && (d[CW-1:0] < CW'(SPR));
    last     = (s == SW'(N_SLOTS - 1));
    rom_addr = '0;
    state_nx = state;
    case (state)
      IDLE: state_nx = IDLE;
      SCAN: begin
        if (hit) rom_addr = d[AW-1:0];
        if (last) state_nx = COMMIT;
      end
      COMMIT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    // A new line request always restarts the scan, dropping any pending commit
    if (line_start) state_nx = SCAN;
  end

  always_comb begin
    on_nx   = 1'b0;
    slot_nx = '0;
    dx      = '0;
    // Walk downwards so the lowest covering slot is the one left standing
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      dx = {1'b0, x} - {1'b0, act_x[i]};
      if (act_val[i] && !dx[CW] && (dx[CW-1:0] < CW'(SPR)) &&
          act_row[i][AW'(SPR - 1) - dx[AW-1:0]]) begin
        on_nx   = 1'b1;
        slot_nx = 4'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      s        <= '0;
      ny       <= '0;
      pix_on   <= 1'b0;
      pix_slot <= '0;
      for (int i = 0; i < N_SLOTS; i++) begin
        cfg_en[i]   <= 1'b0;
        cfg_x[i]    <= '0;
        cfg_y[i]    <= '0;
        shad_row[i] <= '0;
        shad_val[i] <= 1'b0;
        shad_x[i]   <= '0;
        act_row[i]  <= '0;
        act_val[i]  <= 1'b0;
        act_x[i]    <= '0;
      end
    end else begin
      state    <= state_nx;
      pix_on   <= on_nx;
      pix_slot <= slot_nx;
      if (slot_we && ({1'b0, slot_idx} < 5'(N_SLOTS))) begin
        cfg_en[slot_idx[SW-1:0]] <= slot_en;
        cfg_x[slot_idx[SW-1:0]]  <= slot_x;
        cfg_y[slot_idx[SW-1:0]]  <= slot_y;
      end
      if (line_start) begin
        ny <= next_y;
        s  <= '0;
      end else if (state == SCAN && !last) begin
        s <= s + 1'b1;
      end
      if (state == SCAN) begin
        shad_row[s] <= rom_data;
        shad_val[s] <= hit;
        shad_x[s]   <= cfg_x[s];
      end
      if (state == COMMIT && !line_start) begin
        act_row <= shad_row;
        act_val <= shad_val;
        act_x   <= shad_x;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_circle_sprite_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_circle_sprite_scheduler: directed bench with a circle ROM model. Rev 1.0
// ---------------------------------------------------------------------------
module tb_circle_sprite_scheduler;

  localparam int N_SLOTS = 9;

  logic        clk = 1'b0;
  logic        rst;
  logic        line_start;
  logic [9:0]  next_y;
  logic [9:0]  x;
  logic        slot_we;
  logic [3:0]  slot_idx;
  logic        slot_en;
  logic [9:0]  slot_x;
  logic [9:0]  slot_y;
  logic [5:0]  rom_addr;
  logic [63:0] rom_data;
  logic        busy;
  logic        pix_on;
  logic [3:0]  pix_slot;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  circle_sprite_scheduler #(.N_SLOTS(N_SLOTS), .SPR(64), .CW(10)) dut (
    .clk(clk), .rst(rst), .line_start(line_start), .next_y(next_y), .x(x),
    .slot_we(slot_we), .slot_idx(slot_idx), .slot_en(slot_en),
    .slot_x(slot_x), .slot_y(slot_y), .rom_addr(rom_addr), .rom_data(rom_data),
    .busy(busy), .pix_on(pix_on), .pix_slot(pix_slot)
  );

  // Circle of diameter 64; row 10 is replaced by a lone leftmost pixel so the
  // bit-to-column orientation is observable.
  function automatic logic [63:0] rom_row(input logic [5:0] r);
    logic [63:0] v;
    int dr, dc;
    v = '0;
    if (r == 6'd10) begin
      v[63] = 1'b1;
    end else begin
      for (int c = 0; c < 64; c++) begin
        dr = 2 * int'(r) - 63;
        dc = 2 * c - 63;
        if (dr * dr + dc * dc <= 4096) v[63 - c] = 1'b1;
      end
    end
    return v;
  endfunction

  always_comb rom_data = rom_row(rom_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cfg(input logic [3:0] idx, input logic en, input int sx, input int sy);
    @(negedge clk);
    slot_we = 1'b1; slot_idx = idx; slot_en = en; slot_x = 10'(sx); slot_y = 10'(sy);
    @(negedge clk);
    slot_we = 1'b0;
  endtask

  task automatic pulse_line(input int ny);
    @(negedge clk);
    line_start = 1'b1; next_y = 10'(ny);
    @(negedge clk);
    line_start = 1'b0;
  endtask

  // Starts a line, checks the slot-0 ROM address and the busy length
  task automatic run_line(input int ny, input int exp_a0, input string tag);
    int n;
    pulse_line(ny);
    chk({tag, " rom_addr s0"}, 32'(rom_addr), 32'(exp_a0));
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk({tag, " busy cycles"}, 32'(n), 32'(N_SLOTS + 1));
  endtask

  task automatic pix(input int xv, input logic eon, input int eslot, input string tag);
    @(negedge clk);
    x = 10'(xv);
    @(posedge clk);
    #1;
    chk($sformatf("%s x=%0d pix_on", tag, xv), 32'(pix_on), 32'(eon));
    chk($sformatf("%s x=%0d pix_slot", tag, xv), 32'(pix_slot), 32'(eslot));
  endtask

  initial begin
    int e;
    rst = 1'b1; line_start = 1'b0; next_y = '0; x = '0;
    slot_we = 1'b0; slot_idx = '0; slot_en = 1'b0; slot_x = '0; slot_y = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset rom_addr", 32'(rom_addr), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset pix_on", 32'(pix_on), 0);
    chk("reset pix_slot", 32'(pix_slot), 0);

    // 1: slot 0 at (100,50), row 0 covers columns 26..37
    cfg(4'd0, 1'b1, 100, 50);
    run_line(50, 0, "t1");
    for (int xv = 120; xv <= 143; xv++)
      pix(xv, (xv >= 126 && xv <= 137), 0, "t1");

    // 2: row 63 is the last row; one past and one before are misses
    run_line(113, 63, "t2 ny113");
    for (int xv = 124; xv <= 139; xv++)
      pix(xv, (xv >= 126 && xv <= 137), 0, "t2 ny113");
    run_line(114, 0, "t2 ny114");
    pix(100, 1'b0, 0, "t2 ny114"); pix(131, 1'b0, 0, "t2 ny114"); pix(163, 1'b0, 0, "t2 ny114");
    run_line(49, 0, "t2 ny49");
    pix(100, 1'b0, 0, "t2 ny49"); pix(131, 1'b0, 0, "t2 ny49"); pix(163, 1'b0, 0, "t2 ny49");

    // 3: slots 2 and 5 on full row 31, slot 2 wins the overlap
    cfg(4'd0, 1'b0, 100, 50);
    cfg(4'd2, 1'b1, 200, 69);
    cfg(4'd5, 1'b1, 210, 69);
    run_line(100, 0, "t3");
    for (int xv = 196; xv <= 278; xv += 2) begin
      e = (xv >= 200 && xv <= 263) ? 2 : (xv >= 210 && xv <= 273) ? 5 : 0;
      pix(xv, (e != 0), e, "t3");
    end
    pix(263, 1'b1, 2, "t3"); pix(264, 1'b1, 5, "t3"); pix(273, 1'b1, 5, "t3");

    // 4: restart 3 cycles in; only row 1 (columns 22..41) is committed
    pulse_line(100);
    repeat (3) @(negedge clk);
    run_line(70, 0, "t4");
    for (int xv = 218; xv <= 255; xv++) begin
      e = (xv >= 222 && xv <= 241) ? 2 : (xv >= 232 && xv <= 251) ? 5 : 0;
      pix(xv, (e != 0), e, "t4");
    end

    // 5: reset at slot 4 of a scan clears everything; idx 12 write ignored
    pulse_line(100);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5 busy after rst", 32'(busy), 0);
    chk("t5 pix_on after rst", 32'(pix_on), 0);
    pix(222, 1'b0, 0, "t5"); pix(232, 1'b0, 0, "t5"); pix(245, 1'b0, 0, "t5");
    cfg(4'd12, 1'b1, 0, 0);
    run_line(0, 0, "t5 idx12");
    for (int xv = 24; xv <= 40; xv += 2) pix(xv, 1'b0, 0, "t5 idx12");

    // 6: right-edge sprite, orientation marker row then full row, no wrap
    cfg(4'd0, 1'b1, 600, 0);
    run_line(10, 10, "t6 ny10");
    for (int xv = 598; xv <= 604; xv++) pix(xv, (xv == 600), 0, "t6 ny10");
    run_line(31, 31, "t6 ny31");
    for (int xv = 596; xv <= 639; xv++) pix(xv, (xv >= 600), 0, "t6 ny31");
    for (int xv = 0; xv <= 8; xv++) pix(xv, 1'b0, 0, "t6 wrap");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
